// File: rtl/uart_rx_deser.sv
// UART receiver: 2-flop synchronised rx, mid-bit sampling, 8N1 framing with break detection.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_deser #(
  parameter int CLK_PER_BIT = 434,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       new_rx_data,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLK_PER_BIT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic             rx_meta_p0, rx_s;
  logic [7:0]       shift;
  logic             smp_data, smp_par;
  logic             good_nxt, ferr_nxt, perr_nxt;
  logic             par_bad;

  // Input synchroniser: idle-high line, so reset to 1 to avoid a false start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_p0 <= 1'b1;
      rx_s       <= 1'b1;
    end else begin
      rx_meta_p0 <= rx;
      rx_s       <= rx_meta_p0;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  always_ff @(posedge clk) begin
    if (smp_par) par_bit <= rx_s;
  end
  assign par_bad = ^{shift, par_bit};
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (smp_data) shift[idx] <= rx_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    smp_data  = 1'b0;
    smp_par   = 1'b0;
    good_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
    perr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_nxt = '0;
          idx_nxt = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_nxt  = '0;
          smp_data = 1'b1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == FULL_M1) begin
          cnt_nxt   = '0;
          smp_par   = 1'b1;
          state_nxt = STOP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        // Leaving at mid-stop lets a start bit that directly follows be caught.
        if (cnt == FULL_M1) begin
          cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = IDLE;
            perr_nxt  = par_bad;
            good_nxt  = !par_bad;
          end else begin
            state_nxt = BREAK;
            ferr_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      BREAK: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  logic perr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data     <= 8'h00;
      new_rx_data <= 1'b0;
      frame_err   <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      new_rx_data <= good_nxt;
      frame_err   <= ferr_nxt;
      perr_q      <= perr_nxt;
      if (good_nxt) rx_data <= shift;
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: table of frames driven serially, scoreboard of expected pulses.
module tb_uart_rx_deser;
  localparam int N = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // start-edge drive -> 2 sync flops -> half start bit + data/parity/stop bits -> output register
  localparam int LAT = N / 2 + (NBITS - 1) * N + 3;
  localparam int K_GOOD = 0, K_FERR = 1, K_PERR = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       new_rx_data, frame_err, parity_err, busy;

  uart_rx_deser #(.CLK_PER_BIT(N), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int kind; logic [7:0] data; int cyc;} exp_t;
  typedef struct {logic [7:0] data; logic stop; logic par_flip; int hold_low; int gap;} vec_t;

  exp_t       exp_q[$];
  vec_t       tbl[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] model_rx = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (new_rx_data || frame_err || parity_err)) begin
      exp_t e;
      int   kind;
      check("pulse_exclusive", $countones({new_rx_data, frame_err, parity_err}), 1);
      kind = new_rx_data ? K_GOOD : (frame_err ? K_FERR : K_PERR);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse_kind", kind, 99);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", kind, e.kind);
        check("pulse_rx_data", rx_data, e.data);
        check("pulse_cycle", cyc, e.cyc);
        if (new_rx_data) check("busy_on_new_data", busy, 0);
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (N) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input vec_t v);
    exp_t e;
    e.cyc = cyc + LAT;
    if (!v.stop) begin
      e.kind = K_FERR; e.data = model_rx;
    end else if (v.par_flip) begin
      e.kind = K_PERR; e.data = model_rx;
    end else begin
      e.kind = K_GOOD; e.data = v.data; model_rx = v.data;
    end
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(v.data[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^v.data) ^ v.par_flip);
`endif
    drive_bit(v.stop);
    if (v.hold_low > 0) begin
      repeat (v.hold_low) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    if (v.gap > 0) begin
      repeat (v.gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3 * LAT && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int   busy_cnt;
    vec_t v;
    tbl.push_back('{8'hA5, 1'b1, 1'b0, 0,   N});
    tbl.push_back('{8'h3C, 1'b0, 1'b0, 100, N});
    tbl.push_back('{8'h11, 1'b1, 1'b0, 0,   N});
    tbl.push_back('{8'h00, 1'b1, 1'b0, 0,   0});
    tbl.push_back('{8'hFF, 1'b1, 1'b0, 0,   0});
    tbl.push_back('{8'h55, 1'b1, 1'b0, 0,   N});
`ifdef UART_RX_PARITY_EN
    tbl.push_back('{8'h07, 1'b1, 1'b0, 0,   N});
    tbl.push_back('{8'h07, 1'b1, 1'b1, 0,   N});
`endif

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_new_rx_data", new_rx_data, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_parity_err", parity_err, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);

    // Short low glitch: start qualified at mid-bit fails, back to idle silently.
    busy_cnt = 0;
    rx = 1'b0;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
      end
      begin
        repeat (30) begin
          @(negedge clk);
          if (busy) busy_cnt++;
        end
      end
    join
    check("glitch_busy_cycles", busy_cnt, 8);
    check("glitch_rx_data", rx_data, 8'h00);
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) send_frame(tbl[i]);
    drain("table_drain");
    check("table_final_rx_data", rx_data, model_rx);

    // Reset in the middle of bit 4 of a frame.
    v = '{8'h3C, 1'b1, 1'b0, 0, 0};
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(v.data[i]);
    rx = v.data[4];
    repeat (N / 2) @(posedge clk);
    #1;
    check("midframe_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_new_rx_data", new_rx_data, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_parity_err", parity_err, 0);
    check("midrst_busy", busy, 0);
    model_rx = 8'h00;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2 * N) @(posedge clk);
    #1;
    check("post_rst_busy", busy, 0);
    send_frame('{8'h81, 1'b1, 1'b0, 0, N});
    drain("post_rst_drain");
    check("post_rst_rx_data", rx_data, 8'h81);

    repeat (2 * N) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
- UART receive deserializer that sits directly upstream of the command parser.
- Oversamples the asynchronous serial line, validates start, data and stop bits, and presents each good byte as rx_data with a one-cycle new_rx_data strobe.
- Runs in the board clock domain (50 MHz); 8 data bits, LSB first, 1 stop bit, no flow control.

Parameters:
- CLK_PER_BIT, 434, clock cycles per bit (50 MHz / 115200); legal minimum 8.
- CNT_W, 16, width of the bit-timing counter; must hold CLK_PER_BIT-1.

Ports:
- clk  input  1  board clock.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  raw serial line, asynchronous; idle high.
- rx_data  output  8  last correctly received byte; held until the next good byte.
- new_rx_data  output  1  one-cycle pulse: rx_data was updated this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 when UART_RX_PARITY_EN is undefined.
- busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (asynchronous, rst=1):
  - rx_data=8'h00; new_rx_data, frame_err, parity_err and busy all 0.
  - State IDLE; bit counter 0; synchronizer flops set to 1.
- Input path: rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s, so there is 2 cycles of input latency.
- States: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- IDLE:
  - On rx_s==0: go to START, cnt=0.
- START:
  - cnt increments each cycle.
  - At cnt==CLK_PER_BIT/2-1 (mid-bit), re-sample rx_s.
  - rx_s==0: go to DATA, cnt=0, bit index=0.
  - rx_s==1: glitch; return to IDLE with no output pulse.
- DATA:
  - At cnt==CLK_PER_BIT-1, sample rx_s into shift register bit[index] (LSB first), cnt=0.
  - After index 7, go to STOP (or PARITY when enabled).
- PARITY (macro only):
  - At cnt==CLK_PER_BIT-1, sample the parity bit and go to STOP.
- STOP:
  - At cnt==CLK_PER_BIT-1, sample rx_s.
  - rx_s==1, no parity error: the next cycle loads rx_data, pulses new_rx_data, and enters IDLE.
  - rx_s==1, parity error: the next cycle pulses parity_err, leaves rx_data unchanged, and enters IDLE.
  - rx_s==0: the next cycle pulses frame_err, leaves rx_data unchanged, and enters BREAK. This applies regardless of parity.
- BREAK:
  - Stays until rx_s==1, then IDLE. This prevents a held-low line from being decoded as repeated 0x00 bytes.
- Latency: new_rx_data rises CLK_PER_BIT/2 + 9*CLK_PER_BIT + 1 cycles after the rx_s falling edge (+CLK_PER_BIT with parity).
- Pulses:
  - new_rx_data, frame_err and parity_err are mutually exclusive and last exactly 1 cycle.
  - There is no consumer back-pressure: the downstream block must capture within that cycle.
- Back-to-back frames: IDLE is re-entered half a bit into the stop bit, so a start bit that directly follows the stop bit is detected with no lost byte.
- busy=1 in START/DATA/PARITY/STOP/BREAK and 0 in IDLE. The cycle carrying new_rx_data has busy=0.
- Reset mid-frame: the frame is abandoned immediately and no pulse is produced. Reception resumes on the next falling edge after rst deasserts.
- Counter: unsigned CNT_W bits and never wraps. It is reset to 0 on every state change.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - One even-parity bit follows the data bits.
  - Mismatch (XOR of 8 data bits and parity bit != 0) pulses parity_err; rx_data is not updated and new_rx_data is not pulsed.
- Undefined:
  - No PARITY state; 10-bit frame; parity_err constant 0.

Test Plan (CLK_PER_BIT=16):
- Send 0xA5, clean frame -> exactly one new_rx_data pulse; rx_data=0xA5; frame_err=0; busy returns 0 in that cycle.
- 4-cycle low glitch on idle line -> busy high for 8 cycles then 0; no pulse; rx_data remains 0x00.
- Send 0x3C with stop bit forced 0, then hold rx low 100 cycles -> frame_err pulses once; rx_data unchanged; no further pulses until rx goes high; next frame 0x11 is received correctly.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap -> three new_rx_data pulses 160 cycles apart; values match in order.
- Assert rst during bit 4 of a frame -> all outputs 0 within the same cycle; the following 0x81 frame is received correctly.
- With UART_RX_PARITY_EN: 0x07 with parity 1 -> new_rx_data with 0x07; 0x07 with parity 0 -> parity_err pulse; rx_data keeps 0x07 from the previous frame.
